// File: rtl/sbox_pkg.sv
// Shared constants for the serial nibble S-box unit: parameter defaults,
// FSM state encoding and the power-on substitution table.
package sbox_pkg;

    localparam int NIBBLES_DEF = 4;
    localparam int CNT_W_DEF   = 16;

    // Element i of this packed array is TABLE[i]; the leftmost literal is entry F.
    localparam logic [15:0][3:0] SBOX_DEFAULT = {
        4'hE, 4'hF, 4'h0, 4'h9, 4'hA, 4'h4, 4'h1, 4'h8,
        4'hC, 4'h5, 4'h2, 4'h7, 4'hD, 4'h6, 4'h3, 4'h7
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sbox_table.sv
// 16x4 substitution table: synchronous write port, combinational read port,
// restored to the default contents on reset.
module sbox_table
    import sbox_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [3:0] wAddr_i,
    input  logic [3:0] wData_i,
    input  logic [3:0] rAddr_i,
    output logic [3:0] rData_o
);

    logic [15:0][3:0] table_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            table_q <= SBOX_DEFAULT;
        end else if (we_i) begin
            table_q[wAddr_i] <= wData_i;
        end
    end

    assign rData_o = table_q[rAddr_i];

endmodule

// File: rtl/sbox_serial_unit.sv
// Serial S-box: substitutes one nibble per cycle through a shared 16x4 table,
// LSB nibble first, with a valid/ready handshake on both sides.
module sbox_serial_unit
    import sbox_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [4*NIBBLES-1:0] X,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [4*NIBBLES-1:0] Y,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    input  logic                 TBL_WE,
    input  logic [3:0]           TBL_ADDR,
    input  logic [3:0]           TBL_DATA,
    output logic                 TBL_ERR,
    output logic [CNT_W-1:0]     WORD_CNT
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             state_q, state_d;
    logic [W-1:0]       data_q, data_d;
    logic [W-1:0]       y_q, y_d;
    logic [IDX_W-1:0]   nibIdx_q, nibIdx_d;
    logic [CNT_W-1:0]   wordCnt_q, wordCnt_d;
    logic               tblErr_q, tblErr_d;

    logic               tableWe;
    logic [3:0]         curNib;
    logic [3:0]         subNib;
    logic               lastNib;

    // Writes are only safe while no word is mid-substitution.
    assign tableWe = TBL_WE && (state_q == ST_IDLE);
    assign curNib  = data_q[{nibIdx_q, 2'b00} +: 4];
    assign lastNib = (nibIdx_q == IDX_W'(NIBBLES - 1));

    sbox_table u_table (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (tableWe),
        .wAddr_i (TBL_ADDR),
        .wData_i (TBL_DATA),
        .rAddr_i (curNib),
        .rData_o (subNib)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        y_d       = y_q;
        nibIdx_d  = nibIdx_q;
        wordCnt_d = wordCnt_q;
        tblErr_d  = TBL_WE && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    data_d   = X;
                    nibIdx_d = '0;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                data_d[{nibIdx_q, 2'b00} +: 4] = subNib;
                nibIdx_d = nibIdx_q + IDX_W'(1);
                if (lastNib) begin
                    // Y only changes here, so it keeps the last result outside DONE.
                    y_d      = data_d;
                    nibIdx_d = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    wordCnt_d = wordCnt_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            y_q       <= '0;
            nibIdx_q  <= '0;
            wordCnt_q <= '0;
            tblErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            y_q       <= y_d;
            nibIdx_q  <= nibIdx_d;
            wordCnt_q <= wordCnt_d;
            tblErr_q  <= tblErr_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_DONE);
    assign Y         = y_q;
    assign TBL_ERR   = tblErr_q;
    assign WORD_CNT  = wordCnt_q;

endmodule

// File: tb/tb_sbox_serial_unit.sv
// Scoreboard bench for sbox_serial_unit (NIBBLES=4): directed words with
// hand-computed results, checked by an independent output monitor.
module tb_sbox_serial_unit;

    localparam int NIBBLES = 4;
    localparam int CNT_W   = 16;

    logic         CLK;
    logic         RST;
    logic [15:0]  X;
    logic         IN_VALID;
    logic         IN_READY;
    logic [15:0]  Y;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic         TBL_WE;
    logic [3:0]   TBL_ADDR;
    logic [3:0]   TBL_DATA;
    logic         TBL_ERR;
    logic [15:0]  WORD_CNT;

    typedef struct {
        logic [15:0] y;
        int          acceptCycle;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    sbox_serial_unit #(.NIBBLES(NIBBLES), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .X         (X),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .Y         (Y),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .TBL_WE    (TBL_WE),
        .TBL_ADDR  (TBL_ADDR),
        .TBL_DATA  (TBL_DATA),
        .TBL_ERR   (TBL_ERR),
        .WORD_CNT  (WORD_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual %h required %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Offers one word; optionally writes the table on the same edge and keeps IN_VALID high.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] yExp,
                                 input logic we, input logic [3:0] addr, input logic [3:0] data,
                                 input logic keepValid, output int acceptCyc);
        int waited;
        exp_t e;
        @(negedge CLK);
        X        = x;
        IN_VALID = 1'b1;
        TBL_WE   = we;
        TBL_ADDR = addr;
        TBL_DATA = data;
        waited   = 0;
        while (!IN_READY && waited < 64) begin
            @(negedge CLK);
            waited++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("[TB] FAIL acceptTimeout actual busy required ready for x=%h", x);
            IN_VALID  = 1'b0;
            TBL_WE    = 1'b0;
            acceptCyc = -1;
            return;
        end
        acceptCyc     = cycle + 1;
        e.y           = yExp;
        e.acceptCycle = cycle + 1;
        expQ.push_back(e);
        @(negedge CLK);
        TBL_WE = 1'b0;
        if (!keepValid) IN_VALID = 1'b0;
    endtask

    task automatic tableWrite(input logic [3:0] addr, input logic [3:0] data);
        @(negedge CLK);
        TBL_WE   = 1'b1;
        TBL_ADDR = addr;
        TBL_DATA = data;
        @(negedge CLK);
        TBL_WE = 1'b0;
    endtask

    task automatic resetPulse();
        @(negedge CLK);
        RST = 1'b1;
        expQ.delete();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((expQ.size() != 0 || !IN_READY) && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("drainPending", expQ.size(), 0);
        @(negedge CLK);
    endtask

    // Monitor: latency on each rising OUT_VALID, Y compared when the word is taken.
    initial begin
        logic prevValid;
        exp_t e;
        prevValid = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            if (OUT_VALID && !prevValid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedOutput actual Y=%h required no output", Y);
                end else begin
                    checkOutput("latency", cycle - expQ[0].acceptCycle, NIBBLES);
                end
            end
            if (OUT_VALID && OUT_READY && expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput("yData", Y, e.y);
            end
            prevValid = OUT_VALID;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a1, a2, a3, dummy, waited;
        RST       = 1'b1;
        X         = '0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        TBL_WE    = 1'b0;
        TBL_ADDR  = '0;
        TBL_DATA  = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;

        checkOutput("rstInReady",  IN_READY,  1);
        checkOutput("rstOutValid", OUT_VALID, 0);
        checkOutput("rstY",        Y,         0);
        checkOutput("rstTblErr",   TBL_ERR,   0);
        checkOutput("rstWordCnt",  WORD_CNT,  0);

        // Default table substitutions
        applyStimulus(16'h0123, 16'h736D, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        applyStimulus(16'hFEDC, 16'hEF09, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        waitDrain();
        checkOutput("wordCntTwo", WORD_CNT, 2);

        // Stalled consumer plus a rejected write while busy
        OUT_READY = 1'b0;
        applyStimulus(16'h1234, 16'h36D7, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        tableWrite(4'h5, 4'h0);
        checkOutput("tblErrPulse", TBL_ERR, 1);
        @(negedge CLK);
        checkOutput("tblErrClear", TBL_ERR, 0);
        waited = 0;
        while (!OUT_VALID && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        for (int i = 0; i < 10; i++) begin
            checkOutput("stallY",       Y,         16'h36D7);
            checkOutput("stallValid",   OUT_VALID, 1);
            checkOutput("stallInReady", IN_READY,  0);
            @(negedge CLK);
        end
        OUT_READY = 1'b1;
        waitDrain();
        applyStimulus(16'h5555, 16'h2222, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        waitDrain();

        // Idle writes, including one on the same edge as the accept
        tableWrite(4'h0, 4'hA);
        checkOutput("idleWriteNoErr", TBL_ERR, 0);
        applyStimulus(16'h0000, 16'hAAAA, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        applyStimulus(16'h1111, 16'h5555, 1'b1, 4'h1, 4'h5, 1'b0, dummy);
        waitDrain();

        // Reset mid-word discards it and restores the table
        applyStimulus(16'h0000, 16'hAAAA, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        resetPulse();
        checkOutput("midRstInReady",  IN_READY,  1);
        checkOutput("midRstOutValid", OUT_VALID, 0);
        checkOutput("midRstWordCnt",  WORD_CNT,  0);
        checkOutput("midRstY",        Y,         0);
        applyStimulus(16'h0000, 16'h7777, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        applyStimulus(16'h1111, 16'h3333, 1'b0, 4'h0, 4'h0, 1'b0, dummy);
        waitDrain();

        // Back-to-back words with both handshakes held high
        resetPulse();
        applyStimulus(16'h0123, 16'h736D, 1'b0, 4'h0, 4'h0, 1'b1, a1);
        applyStimulus(16'hFEDC, 16'hEF09, 1'b0, 4'h0, 4'h0, 1'b1, a2);
        applyStimulus(16'h0000, 16'h7777, 1'b0, 4'h0, 4'h0, 1'b0, a3);
        checkOutput("spacing12", a2 - a1, NIBBLES + 2);
        checkOutput("spacing23", a3 - a2, NIBBLES + 2);
        waitDrain();
        checkOutput("wordCntThree", WORD_CNT, 3);

        repeat (2) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
